clock_signal: RTL and testbench

//   Manual single-step clock source for the toy processor. Synchronizes the

---
 rtl/clock_signal.sv | 136 +++++++++++++
 tb/tb_clock_signal.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/clock_signal.sv
// Manual single-step clock: sync + debounce PUSH, emit a PULSE_WIDTH pulse on SIG.
// Optional auto-repeat while held: define CLOCK_SIGNAL_AUTOREPEAT_EN.
module clock_signal #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_WIDTH     = 1
`ifdef CLOCK_SIGNAL_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
`endif
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PUSH,
  output logic SIG
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam logic [CW-1:0] DC_M1 = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PW_M1 = PW'(PULSE_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_out;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   deb_q;
  logic                   deb_d;
  logic                   sig_q;
  logic                   sig_d;
  logic [PW-1:0]          pcnt_q;
  logic [PW-1:0]          pcnt_d;
  logic                   press;
  logic                   fire;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], PUSH};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign press    = deb_d & ~deb_q;
  assign SIG      = sig_q;

  // Debounce: accept a new level after DEBOUNCE_CYCLES differing edges
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_out != deb_q) begin
      if (cnt_q == DC_M1) begin
        deb_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef CLOCK_SIGNAL_AUTOREPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] RD = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] RP = HW'(REPEAT_PERIOD);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [HW-1:0] tgt;
  logic          rep_q;
  logic          rep_d;

  // Hold counter: cycles since last pulse start while the button stays down
  always_comb begin
    hold_d = '0;
    rep_d  = 1'b0;
    fire   = 1'b0;
    tgt    = rep_q ? RP : RD;
    if (press) begin
      hold_d = HW'(1);
    end else if (deb_q && deb_d) begin
      if (hold_q == tgt) begin
        fire   = 1'b1;
        hold_d = HW'(1);
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
        rep_d  = rep_q;
      end
    end
  end

  // Hold counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign fire = 1'b0;
`endif

  // Pulse generator: a start while SIG is high is ignored
  always_comb begin
    sig_d  = sig_q;
    pcnt_d = pcnt_q;
    if (sig_q) begin
      if (pcnt_q == '0) begin
        sig_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q - 1'b1;
      end
    end else if (press || fire) begin
      sig_d  = 1'b1;
      pcnt_d = PW_M1;
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      sig_q  <= 1'b0;
      pcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      sig_q  <= sig_d;
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_clock_signal.sv
// Bench for clock_signal: default, DEBOUNCE_CYCLES=3 and PULSE_WIDTH=3 instances.
// Directed table on the default instance plus hand sequences.
module tb_clock_signal;

  logic CLK;
  logic rst0, push0, sig0;
  logic rst1, push1, sig1;
  logic rst2, push2, sig2;

  int n_chk;
  int n_fail;

  typedef struct {
    logic rst;
    logic push;
    logic sig;
  } vec_t;

  vec_t tbl [23];

  clock_signal dut0 (
    .CLK(CLK), .RST_N(rst0), .PUSH(push0), .SIG(sig0)
  );

  clock_signal #(.DEBOUNCE_CYCLES(3)) dut1 (
    .CLK(CLK), .RST_N(rst1), .PUSH(push1), .SIG(sig1)
  );

  clock_signal #(.PULSE_WIDTH(3)) dut2 (
    .CLK(CLK), .RST_N(rst2), .PUSH(push2), .SIG(sig2)
  );

  initial CLK = 1'b0;
  always #100 CLK = ~CLK;

  task automatic chk(input string nm, input int idx,
                     input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: SIG=%b expected %b at %0t",
               nm, idx, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #100;
  endtask

  task automatic set_row(input int i, input logic r,
                         input logic p, input logic s);
    tbl[i].rst  = r;
    tbl[i].push = p;
    tbl[i].sig  = s;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst0 = 1'b0; push0 = 1'b0;
    rst1 = 1'b0; push1 = 1'b0;
    rst2 = 1'b0; push2 = 1'b0;

    set_row(0,  1'b0, 1'b0, 1'b0);
    set_row(1,  1'b1, 1'b1, 1'b0);
    set_row(2,  1'b1, 1'b0, 1'b0);
    set_row(3,  1'b1, 1'b0, 1'b1);
    set_row(4,  1'b1, 1'b1, 1'b0);
    set_row(5,  1'b1, 1'b1, 1'b0);
    set_row(6,  1'b1, 1'b1, 1'b1);
    set_row(7,  1'b1, 1'b0, 1'b0);
    for (int i = 8; i <= 12; i++) set_row(i, 1'b1, 1'b0, 1'b0);
    set_row(13, 1'b0, 1'b1, 1'b0);
    set_row(14, 1'b0, 1'b1, 1'b0);
    set_row(15, 1'b1, 1'b1, 1'b0);
    set_row(16, 1'b1, 1'b1, 1'b0);
    set_row(17, 1'b1, 1'b1, 1'b1);
    set_row(18, 1'b1, 1'b1, 1'b0);
    for (int i = 19; i <= 22; i++) set_row(i, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 23; k++) begin
      #85;
      rst0  = tbl[k].rst;
      push0 = tbl[k].push;
      tick();
      chk("table", k, sig0, tbl[k].sig);
    end

    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    for (int e = 0; e < 10; e++) begin
      push1 = (e < 2);
      tick();
      chk("db_short", e, sig1, 1'b0);
    end
    for (int e = 0; e < 10; e++) begin
      push1 = (e < 3);
      tick();
      chk("db_long", e, sig1, e == 4);
    end

    rst2 = 1'b0;
    tick();
    rst2 = 1'b1;
    for (int e = 0; e < 10; e++) begin
      push2 = (e < 6);
      tick();
      chk("pw3", e, sig2, (e >= 2) && (e <= 4));
    end
    for (int e = 0; e < 10; e++) begin
      push2 = (e == 0) || (e == 2) || (e == 3);
      tick();
      chk("pw3_rearm", e, sig2, (e >= 2) && (e <= 4));
    end
    for (int e = 0; e < 6; e++) begin
      push2 = 1'b1;
      rst2  = (e != 3);
      tick();
      chk("pw3_rst", e, sig2, e == 2);
    end
    push2 = 1'b0;
    rst2  = 1'b1;

    for (int e = 0; e < 71; e++) begin
      push0 = (e <= 42);
      tick();
`ifdef CLOCK_SIGNAL_AUTOREPEAT_EN
      chk("hold", e, sig0,
          (e == 2) || (e == 18) || (e == 26) || (e == 34) || (e == 42));
`else
      chk("hold", e, sig0, e == 2);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
